// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the sized data memory.
package dmem_pkg;

  // Access size encodings carried on size_i.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } state_e;

  // Number of bytes touched by an access; 0 flags the illegal encoding.
  function automatic logic [2:0] nbytes(input logic [1:0] size);
    logic [2:0] n;
    unique case (size)
      SZ_B:    n = 3'd1;
      SZ_H:    n = 3'd2;
      SZ_W:    n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/data_memory_sized_if.sv
// Request/response bundle between the MEM stage and the sized data memory.
interface data_memory_sized_if;

  logic        req_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        ready_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] data_o;

  modport master (
    output req_i, we_i, size_i, unsigned_i, addr_i, data_i,
    input  ready_o, done_o, err_o, data_o
  );

  modport slave (
    input  req_i, we_i, size_i, unsigned_i, addr_i, data_i,
    output ready_o, done_o, err_o, data_o
  );

endinterface

// File: rtl/dmem_load_align.sv
// Extends the little-endian assembled load bytes to 32 bits per access size.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] bytes_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  // Zero- or sign-extend the low byte/half; words pass through.
  always_comb begin
    data_o = bytes_i;
    unique case (size_i)
      SZ_B:    data_o = {{24{~unsigned_i & bytes_i[7]}}, bytes_i[7:0]};
      SZ_H:    data_o = {{16{~unsigned_i & bytes_i[15]}}, bytes_i[15:0]};
      default: data_o = bytes_i;
    endcase
  end

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressable little-endian data memory with sized accesses and wait states.
module data_memory_sized
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input logic               clk_i,
  input logic               rst_i,
  data_memory_sized_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);

  logic [7:0]    mem_q [DEPTH_BYTES];
  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ready, accept, fire;

  logic          we_q, uns_q;
  logic [1:0]    size_q;
  logic [31:0]   addr_q, wdata_q;

  logic          acc_we, acc_uns, acc_err;
  logic [1:0]    acc_size;
  logic [31:0]   acc_addr, acc_wdata;
  logic [32:0]   end_addr;
  logic [AW-1:0] idx0, idx1, idx2, idx3;
  logic          wr_en;
  logic [31:0]   load_data;

  logic          done_q, err_q;
  logic [31:0]   rdata_q;

  assign ready  = (state_q == StIdle);
  assign accept = bus.req_i & ready;

  // Zero-wait accesses act on the live request; otherwise on the captured one.
  always_comb begin
    if (WAIT_CYCLES == 0) begin
      acc_we    = bus.we_i;
      acc_uns   = bus.unsigned_i;
      acc_size  = bus.size_i;
      acc_addr  = bus.addr_i;
      acc_wdata = bus.data_i;
    end else begin
      acc_we    = we_q;
      acc_uns   = uns_q;
      acc_size  = size_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  // Misalignment, range (33-bit so upper address bits count) and illegal-size checks.
  always_comb begin
    end_addr = {1'b0, acc_addr} + 33'(nbytes(acc_size)) - 33'd1;
    acc_err  = (acc_size == SZ_X)
             | ((acc_size == SZ_H) & acc_addr[0])
             | ((acc_size == SZ_W) & (|acc_addr[1:0]))
             | (end_addr >= 33'(DEPTH_BYTES));
  end

  assign idx0 = acc_addr[AW-1:0];
  assign idx1 = idx0 + AW'(1);
  assign idx2 = idx0 + AW'(2);
  assign idx3 = idx0 + AW'(3);

  // FSM next-state: count down wait states, fire the access when the count expires.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            fire = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          fire    = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and counter registers; reset drops any in-flight access.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request on accept for the wait-state path.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q    <= bus.we_i;
      uns_q   <= bus.unsigned_i;
      size_q  <= bus.size_i;
      addr_q  <= bus.addr_i;
      wdata_q <= bus.data_i;
    end
  end

  assign wr_en = fire & acc_we & ~acc_err & ~rst_i;

  // Byte-lane writes; the array is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[idx0] <= acc_wdata[7:0];
      if (acc_size != SZ_B) mem_q[idx1] <= acc_wdata[15:8];
      if (acc_size == SZ_W) begin
        mem_q[idx2] <= acc_wdata[23:16];
        mem_q[idx3] <= acc_wdata[31:24];
      end
    end
  end

  dmem_load_align u_load_align (
    .bytes_i    ({mem_q[idx3], mem_q[idx2], mem_q[idx1], mem_q[idx0]}),
    .size_i     (acc_size),
    .unsigned_i (acc_uns),
    .data_o     (load_data)
  );

  // Response registers: done/err pulse with the access, load data held otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      done_q <= fire;
      err_q  <= fire & acc_err;
      if (fire & ~acc_err & ~acc_we) rdata_q <= load_data;
    end
  end

  assign bus.ready_o = ready;
  assign bus.done_o  = done_q;
  assign bus.err_o   = err_q;
  assign bus.data_o  = rdata_q;

endmodule
